// File: rtl/wakeup_broadcast_arbiter_pkg.sv
// Shared wakeup-path definitions: default sizing and the round-robin first-set-bit search.
// The issue queue imports the same package for its own select logic.
package wakeup_broadcast_arbiter_pkg;

   localparam int WB_NUM_PHYS_REGS = 64;
   localparam int WB_LOG_PHYS      = $clog2(WB_NUM_PHYS_REGS);
   localparam int WB_NUM_SOURCES   = 4;
   localparam int WB_FIFO_DEPTH    = 2;

   localparam int RR_MAX   = 16;
   localparam int RR_IDX_W = 4;
   localparam int RR_CNT_W = RR_IDX_W + 1;

   typedef struct packed {
      logic                found;
      logic [RR_IDX_W-1:0] idx;
   } rr_pick_t;

   // First set bit of req[n-1:0], scanning ptr, ptr+1, ... modulo n.
   function automatic rr_pick_t rr_first_set(input logic [RR_MAX-1:0]   req,
                                             input logic [RR_IDX_W-1:0] ptr,
                                             input logic [RR_CNT_W-1:0] n);
      rr_pick_t            pick;
      logic [RR_CNT_W-1:0] sum;
      logic [RR_CNT_W-1:0] cand;
      pick.found = 1'b0;
      pick.idx   = {RR_IDX_W{1'b0}};
      for (int k = 0; k < RR_MAX; k++) begin
         sum  = {1'b0, ptr} + RR_CNT_W'(k);
         cand = (sum >= n) ? (sum - n) : sum;
         if (!pick.found && (RR_CNT_W'(k) < n) && req[cand[RR_IDX_W-1:0]]) begin
            pick.found = 1'b1;
            pick.idx   = cand[RR_IDX_W-1:0];
         end else begin
            pick = pick;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/wakeup_src_fifo.sv
// Per-source event FIFO: power-of-two depth, wrapping pointers, head visible combinationally.
// Callers gate push with ~full and pop with ~empty.
module wakeup_src_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 6
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;

   // Pointers, count and storage; reset drops all buffered entries.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (push) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + CW'(1'b1);
            2'b01:   count_r <= count_r - CW'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign full  = (count_r == CW'(DEPTH));
   assign empty = (count_r == {CW{1'b0}});
   assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/wakeup_broadcast_arbiter.sv
// Merges writeback ready-register events from several producers into the issue queue's
// single wakeup port, one round-robin winner per non-held cycle.
module wakeup_broadcast_arbiter
   import wakeup_broadcast_arbiter_pkg::*;
#(
   parameter  int NUM_PHYS_REGS = WB_NUM_PHYS_REGS,
   parameter  int NUM_SOURCES   = WB_NUM_SOURCES,
   parameter  int FIFO_DEPTH    = WB_FIFO_DEPTH,
   localparam int LOG_PHYS      = $clog2(NUM_PHYS_REGS),
   localparam int OCC_W         = $clog2(NUM_SOURCES*FIFO_DEPTH+1)
) (
   input  logic                            CLK,
   input  logic                            RESET,
   input  logic [NUM_SOURCES-1:0]          WbValid_IN,
   input  logic [NUM_SOURCES*LOG_PHYS-1:0] WbReg_IN,
   output logic [NUM_SOURCES-1:0]          WbAccept_OUT,
   input  logic                            Hold_IN,
   output logic                            ReadyUpdate_OUT,
   output logic [LOG_PHYS-1:0]             ReadyRegister_OUT,
   output logic [OCC_W-1:0]                Occupancy_OUT
);

   localparam int PTR_W = $clog2(NUM_SOURCES);

   logic [NUM_SOURCES-1:0] push_s;
   logic [NUM_SOURCES-1:0] pop_s;
   logic [NUM_SOURCES-1:0] full_s;
   logic [NUM_SOURCES-1:0] empty_s;
   logic [LOG_PHYS-1:0]    head_s [NUM_SOURCES];
   rr_pick_t               pick_s;
   logic                   grant_s;
   logic [PTR_W-1:0]       grant_idx_s;
   logic [PTR_W-1:0]       rr_next_s;
   logic [OCC_W-1:0]       push_cnt_s;
   logic [OCC_W-1:0]       occ_next_s;

   logic [PTR_W-1:0]       rr_ptr_r;
   logic                   ready_update_r;
   logic [LOG_PHYS-1:0]    ready_register_r;
   logic [OCC_W-1:0]       occupancy_r;

   assign WbAccept_OUT = ~full_s;
   assign push_s       = WbValid_IN & ~full_s;

   for (genvar s = 0; s < NUM_SOURCES; s++) begin : g_src
      wakeup_src_fifo #(
         .DEPTH (FIFO_DEPTH),
         .WIDTH (LOG_PHYS)
      ) u_fifo (
         .CLK       (CLK),
         .RESET     (RESET),
         .push      (push_s[s]),
         .pop       (pop_s[s]),
         .push_data (WbReg_IN[s*LOG_PHYS +: LOG_PHYS]),
         .full      (full_s[s]),
         .empty     (empty_s[s]),
         .head      (head_s[s])
      );
   end

   // Grant from registered non-empty state only, so a same-cycle push never wins.
   always_comb begin
      pick_s      = rr_first_set(RR_MAX'(~empty_s), RR_IDX_W'(rr_ptr_r), RR_CNT_W'(NUM_SOURCES));
      grant_s     = pick_s.found & ~Hold_IN;
      grant_idx_s = PTR_W'(pick_s.idx);
      pop_s       = {NUM_SOURCES{1'b0}};
      if (grant_s) begin
         pop_s[grant_idx_s] = 1'b1;
      end else begin
         pop_s = {NUM_SOURCES{1'b0}};
      end
      rr_next_s = (grant_idx_s == PTR_W'(NUM_SOURCES-1)) ? {PTR_W{1'b0}}
                                                         : grant_idx_s + PTR_W'(1'b1);
      push_cnt_s = {OCC_W{1'b0}};
      for (int s = 0; s < NUM_SOURCES; s++) begin
         push_cnt_s = push_cnt_s + OCC_W'(push_s[s]);
      end
      occ_next_s = occupancy_r + push_cnt_s - OCC_W'(grant_s);
   end

   // Broadcast registers, round-robin pointer and occupancy.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         rr_ptr_r         <= {PTR_W{1'b0}};
         ready_update_r   <= 1'b0;
         ready_register_r <= {LOG_PHYS{1'b0}};
         occupancy_r      <= {OCC_W{1'b0}};
      end else begin
         occupancy_r <= occ_next_s;
         if (grant_s) begin
            ready_update_r   <= 1'b1;
            ready_register_r <= head_s[grant_idx_s];
            rr_ptr_r         <= rr_next_s;
         end else begin
            ready_update_r   <= 1'b0;
         end
      end
   end

   assign ReadyUpdate_OUT   = ready_update_r;
   assign ReadyRegister_OUT = ready_register_r;
   assign Occupancy_OUT     = occupancy_r;

endmodule
